// File: rtl/led_line_receiver.sv
// Receive side of the LED-strip SPI line: recovers start/pixel/end frames into a line buffer.
// Optional frame-abort timeout is built in when LED_LINE_RX_TIMEOUT_EN is defined.
module led_line_receiver #(
    parameter int unsigned ADD_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_data,
    output logic [ADD_WIDTH-1:0] address,
    output logic [31:0]          pixel,
    output logic                 pixel_valid,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic [ADD_WIDTH:0]   pixel_count,
    output logic                 overflow,
    output logic                 err,
    output logic                 busy
);

    typedef enum logic {StHunt, StData} state_e;

    localparam logic [ADD_WIDTH:0] CountMax = '1;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic sdat_meta_q, sdat_sync_q;
    logic sclk_rise;
    logic [31:0] word;

    state_e                state_q, state_d;
    logic [31:0]           shift_q, shift_d;
    logic [5:0]            zero_cnt_q, zero_cnt_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [ADD_WIDTH-1:0]  address_q, address_d;
    logic [31:0]           pixel_q, pixel_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic [ADD_WIDTH:0]    pixel_count_q, pixel_count_d;
    logic                  overflow_q, overflow_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

`ifdef LED_LINE_RX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign word      = {shift_q[30:0], sdat_sync_q};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        zero_cnt_d    = zero_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        address_d     = address_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        pixel_count_d = pixel_count_q;
        overflow_d    = overflow_q;
        err_d         = 1'b0;
`ifdef LED_LINE_RX_TIMEOUT_EN
        tmo_cnt_d     = '0;
`endif

        if (sclk_rise) begin
            shift_d = word;
        end
        // Address advances the cycle after its strobe so it is stable while written.
        if (pixel_valid_q) begin
            address_d = address_q + ADD_WIDTH'(1);
        end

        unique case (state_q)
            StHunt: begin
                if (sclk_rise) begin
                    if (sdat_sync_q) begin
                        zero_cnt_d = '0;
                    end else if (zero_cnt_q == 6'd31) begin
                        state_d       = StData;
                        zero_cnt_d    = '0;
                        bit_cnt_d     = '0;
                        address_d     = '0;
                        pixel_count_d = '0;
                        overflow_d    = 1'b0;
                        frame_start_d = 1'b1;
                    end else begin
                        zero_cnt_d = zero_cnt_q + 6'd1;
                    end
                end
            end
            StData: begin
`ifdef LED_LINE_RX_TIMEOUT_EN
                // An edge in the expiry cycle wins: it clears the counter first.
                if (!sclk_rise) begin
                    if (tmo_cnt_q == TmoLast) begin
                        err_d      = 1'b1;
                        state_d    = StHunt;
                        bit_cnt_d  = '0;
                        zero_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    end
                end
`endif
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        bit_cnt_d = '0;
                        if (word == 32'hFFFF_FFFF) begin
                            frame_done_d = 1'b1;
                            state_d      = StHunt;
                        end else if (word == 32'h0000_0000) begin
                            frame_start_d = 1'b1;
                            address_d     = '0;
                            pixel_count_d = '0;
                            overflow_d    = 1'b0;
                        end else if (word[31:29] == 3'b111) begin
                            // Top count bit clear means a free slot remains.
                            if (!pixel_count_q[ADD_WIDTH]) begin
                                pixel_d       = word;
                                pixel_valid_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                            if (pixel_count_q != CountMax) begin
                                pixel_count_d = pixel_count_q + 1'b1;
                            end
                        end else begin
                            err_d      = 1'b1;
                            state_d    = StHunt;
                            zero_cnt_d = '0;
                        end
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        busy_d = (state_d == StData);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta_q   <= 1'b0;
            sclk_sync_q   <= 1'b0;
            sclk_prev_q   <= 1'b0;
            sdat_meta_q   <= 1'b0;
            sdat_sync_q   <= 1'b0;
            state_q       <= StHunt;
            shift_q       <= '0;
            zero_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            address_q     <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            overflow_q    <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
`ifdef LED_LINE_RX_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            sclk_meta_q   <= spi_clk;
            sclk_sync_q   <= sclk_meta_q;
            sclk_prev_q   <= sclk_sync_q;
            sdat_meta_q   <= spi_data;
            sdat_sync_q   <= sdat_meta_q;
            state_q       <= state_d;
            shift_q       <= shift_d;
            zero_cnt_q    <= zero_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            address_q     <= address_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            overflow_q    <= overflow_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
`ifdef LED_LINE_RX_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign address     = address_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign pixel_count = pixel_count_q;
    assign overflow    = overflow_q;
    assign err         = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_led_line_receiver.sv
// Directed bench for led_line_receiver: an 8-bit-address instance plus a 2-bit one for overflow.
// With LED_LINE_RX_TIMEOUT_EN defined, a third instance checks the frame-abort timeout.
module tb_led_line_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_data = 1'b0;

    logic [7:0]  a_address;
    logic [31:0] a_pixel;
    logic        a_pixel_valid, a_frame_start, a_frame_done, a_overflow, a_err, a_busy;
    logic [8:0]  a_pixel_count;

    logic [1:0]  b_address;
    logic [31:0] b_pixel;
    logic        b_pixel_valid, b_frame_start, b_frame_done, b_overflow, b_err, b_busy;
    logic [2:0]  b_pixel_count;

    int tests = 0;
    int fails = 0;
    time last_rise = 0;

    always #5 clk = ~clk;

    led_line_receiver #(.ADD_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_data(spi_data),
        .address(a_address), .pixel(a_pixel), .pixel_valid(a_pixel_valid),
        .frame_start(a_frame_start), .frame_done(a_frame_done), .pixel_count(a_pixel_count),
        .overflow(a_overflow), .err(a_err), .busy(a_busy)
    );

    led_line_receiver #(.ADD_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_data(spi_data),
        .address(b_address), .pixel(b_pixel), .pixel_valid(b_pixel_valid),
        .frame_start(b_frame_start), .frame_done(b_frame_done), .pixel_count(b_pixel_count),
        .overflow(b_overflow), .err(b_err), .busy(b_busy)
    );

    // Pulse counters and write logs; tests compare deltas across a scenario.
    int a_fs = 0, a_fd = 0, a_er = 0, b_fs = 0, b_fd = 0, b_er = 0;
    logic [7:0]  a_wa[$];
    logic [31:0] a_wd[$];
    logic [1:0]  b_wa[$];
    logic [31:0] b_wd[$];

    always @(negedge clk) begin
        if (a_frame_start) a_fs <= a_fs + 1;
        if (a_frame_done)  a_fd <= a_fd + 1;
        if (a_err)         a_er <= a_er + 1;
        if (b_frame_start) b_fs <= b_fs + 1;
        if (b_frame_done)  b_fd <= b_fd + 1;
        if (b_err)         b_er <= b_er + 1;
        if (a_pixel_valid) begin
            a_wa.push_back(a_address);
            a_wd.push_back(a_pixel);
        end
        if (b_pixel_valid) begin
            b_wa.push_back(b_address);
            b_wd.push_back(b_pixel);
        end
    end

`ifdef LED_LINE_RX_TIMEOUT_EN
    logic [7:0]  c_address;
    logic [31:0] c_pixel;
    logic        c_pixel_valid, c_frame_start, c_frame_done, c_overflow, c_err, c_busy;
    logic [8:0]  c_pixel_count;
    int  c_er = 0, c_wr = 0;
    time c_err_time = 0;

    led_line_receiver #(.ADD_WIDTH(8), .TIMEOUT_CYCLES(64)) u_c (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_data(spi_data),
        .address(c_address), .pixel(c_pixel), .pixel_valid(c_pixel_valid),
        .frame_start(c_frame_start), .frame_done(c_frame_done), .pixel_count(c_pixel_count),
        .overflow(c_overflow), .err(c_err), .busy(c_busy)
    );

    always @(negedge clk) begin
        if (c_err) begin
            c_er       <= c_er + 1;
            c_err_time <= $time;
        end
        if (c_pixel_valid) c_wr <= c_wr + 1;
    end
`endif

    task automatic send_bit(input logic b);
        @(negedge clk);
        spi_data = b;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        last_rise = $time;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_address, a_pixel, a_pixel_valid, a_frame_start, a_frame_done, a_pixel_count,
             a_overflow, a_err, a_busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: addr=%h pix=%h pc=%0d busy=%b required all zero",
                     a_address, a_pixel, a_pixel_count, a_busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int fs0 = a_fs, fd0 = a_fd, er0 = a_er, w0 = a_wa.size();
        logic [31:0] exp_d [3] = '{32'hE1FF0000, 32'hE100FF00, 32'hE10000FF};
        send_word(32'h0);
        for (int i = 0; i < 3; i++) send_word(exp_d[i]);
        send_word(32'hFFFF_FFFF);
        settle();
        tests++;
        if (a_fs - fs0 !== 1) begin fails++; $display("FAIL basic_start: %0d vs 1", a_fs - fs0); end
        tests++;
        if (a_fd - fd0 !== 1) begin fails++; $display("FAIL basic_done: %0d vs 1", a_fd - fd0); end
        tests++;
        if (a_er - er0 !== 0) begin fails++; $display("FAIL basic_err: %0d vs 0", a_er - er0); end
        tests++;
        if (a_wa.size() - w0 !== 3) begin
            fails++; $display("FAIL basic_writes: %0d vs 3", a_wa.size() - w0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (a_wa[w0+i] !== 8'(i) || a_wd[w0+i] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL basic_write%0d: addr=%0d data=%h vs addr=%0d data=%h",
                             i, a_wa[w0+i], a_wd[w0+i], i, exp_d[i]);
                end
            end
        end
        tests++;
        if (a_pixel_count !== 9'd3 || a_address !== 8'd3 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_state: pc=%0d addr=%0d busy=%b vs 3 3 0",
                     a_pixel_count, a_address, a_busy);
        end
    endtask

    task automatic test_double_start();
        int fs0 = a_fs, w0 = a_wa.size();
        send_word(32'h0);
        send_word(32'h0);
        send_word(32'hE0ABCDEF);
        send_word(32'hFFFF_FFFF);
        settle();
        tests++;
        if (a_fs - fs0 !== 2) begin fails++; $display("FAIL dbl_start: %0d vs 2", a_fs - fs0); end
        tests++;
        if (a_wa.size() - w0 !== 1 || a_wa[$] !== 8'd0 || a_wd[$] !== 32'hE0ABCDEF) begin
            fails++;
            $display("FAIL dbl_write: n=%0d addr=%0d data=%h vs 1 0 e0abcdef",
                     a_wa.size() - w0, a_wa[$], a_wd[$]);
        end
        tests++;
        if (a_pixel_count !== 9'd1) begin
            fails++; $display("FAIL dbl_count: %0d vs 1", a_pixel_count);
        end
    endtask

    task automatic test_framing_error();
        int er0 = a_er, w0 = a_wa.size();
        send_word(32'h0);
        send_word(32'h12345678);
        settle();
        tests++;
        if (a_er - er0 !== 1 || a_busy !== 1'b0 || a_wa.size() !== w0) begin
            fails++;
            $display("FAIL ferr: errs=%0d busy=%b writes=%0d vs 1 0 0",
                     a_er - er0, a_busy, a_wa.size() - w0);
        end
        send_word(32'h0);
        send_word(32'hE7654321);
        send_word(32'hFFFF_FFFF);
        settle();
        tests++;
        if (a_wa.size() - w0 !== 1 || a_wa[$] !== 8'd0 || a_wd[$] !== 32'hE7654321 ||
            a_pixel_count !== 9'd1) begin
            fails++;
            $display("FAIL ferr_recover: n=%0d addr=%0d data=%h pc=%0d vs 1 0 e7654321 1",
                     a_wa.size() - w0, a_wa[$], a_wd[$], a_pixel_count);
        end
    endtask

    task automatic test_overflow();
        int wa0 = a_wa.size(), wb0 = b_wa.size();
        send_word(32'h0);
        for (int i = 0; i < 6; i++) send_word(32'hE000_0000 + i);
        send_word(32'hFFFF_FFFF);
        settle();
        tests++;
        if (b_wa.size() - wb0 !== 4) begin
            fails++; $display("FAIL ovf_writes: %0d vs 4", b_wa.size() - wb0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (b_wa[wb0+i] !== 2'(i) || b_wd[wb0+i] !== 32'hE000_0000 + i) begin
                    fails++;
                    $display("FAIL ovf_write%0d: addr=%0d data=%h vs %0d %h",
                             i, b_wa[wb0+i], b_wd[wb0+i], i, 32'hE000_0000 + i);
                end
            end
        end
        tests++;
        if (b_overflow !== 1'b1 || b_pixel_count !== 3'd6) begin
            fails++; $display("FAIL ovf_state: ovf=%b pc=%0d vs 1 6", b_overflow, b_pixel_count);
        end
        tests++;
        if (a_wa.size() - wa0 !== 6 || a_overflow !== 1'b0 || a_pixel_count !== 9'd6) begin
            fails++;
            $display("FAIL ovf_wide: n=%0d ovf=%b pc=%0d vs 6 0 6",
                     a_wa.size() - wa0, a_overflow, a_pixel_count);
        end
        send_word(32'h0);
        settle();
        tests++;
        if (b_overflow !== 1'b0 || b_pixel_count !== 3'd0 || b_busy !== 1'b1) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b pc=%0d busy=%b vs 0 0 1",
                     b_overflow, b_pixel_count, b_busy);
        end
        send_word(32'hFFFF_FFFF);
        settle();
    endtask

    task automatic test_reset_midframe();
        int w0;
        send_word(32'h0);
        send_word(32'hE5555555);
        for (int i = 0; i < 17; i++) send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({a_address, a_pixel, a_pixel_valid, a_frame_start, a_frame_done, a_pixel_count,
                 a_overflow, a_err, a_busy} !== '0) begin
                fails++;
                $display("FAIL rst_mid%0d: addr=%h pix=%h pc=%0d busy=%b vs all zero",
                         i, a_address, a_pixel, a_pixel_count, a_busy);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        w0 = a_wa.size();
        send_word(32'h0);
        send_word(32'hE0C0FFEE);
        send_word(32'hFFFF_FFFF);
        settle();
        tests++;
        if (a_wa.size() - w0 !== 1 || a_wa[$] !== 8'd0 || a_wd[$] !== 32'hE0C0FFEE ||
            a_pixel_count !== 9'd1) begin
            fails++;
            $display("FAIL rst_recover: n=%0d addr=%0d data=%h pc=%0d vs 1 0 e0c0ffee 1",
                     a_wa.size() - w0, a_wa[$], a_wd[$], a_pixel_count);
        end
    endtask

`ifdef LED_LINE_RX_TIMEOUT_EN
    task automatic test_timeout();
        int er0 = c_er, wr0 = c_wr, waited = 0;
        time delta;
        send_word(32'h0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        while (c_er == er0 && waited < 150) begin
            @(negedge clk);
            waited++;
        end
        delta = (c_err_time - last_rise) / 10;
        tests++;
        if (c_er - er0 !== 1 || delta < 64 || delta > 70) begin
            fails++;
            $display("FAIL timeout: errs=%0d cycles=%0d vs 1 in 64..70", c_er - er0, delta);
        end
        tests++;
        if (c_busy !== 1'b0 || c_wr !== wr0) begin
            fails++;
            $display("FAIL timeout_state: busy=%b writes=%0d vs 0 0", c_busy, c_wr - wr0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_double_start();
        test_framing_error();
        test_overflow();
        test_reset_midframe();
`ifdef LED_LINE_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
